// File: rtl/syn_acache_ctrl.sv
// Audio sample cache controller: streams PCM samples into an external dual-port RAM
// in free-running (NORMAL) or one-shot (CAPTURE) mode. Define SYN_ACACHE_OVFL_CNT_EN for the ovfl_cnt port.
module syn_acache_ctrl #(
    parameter int DEPTH_W = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               bps,
    input  logic               cap_start,
    input  logic               pcm_valid,
    input  logic [63:0]        pcm_data,
    output logic               pcm_ready,
    output logic               ram_wr_en,
    output logic [DEPTH_W-1:0] ram_waddr,
    output logic [31:0]        ram_wdata,
    output logic [DEPTH_W-1:0] ram_raddr,
    input  logic [31:0]        ram_rdata,
    input  logic               host_rd_req,
    input  logic [DEPTH_W-1:0] host_rd_addr,
    output logic               host_rd_valid,
    output logic [31:0]        host_rd_data,
    output logic               cap_busy,
    output logic               cap_done,
    output logic [DEPTH_W:0]   fill_cnt
`ifdef SYN_ACACHE_OVFL_CNT_EN
    ,
    output logic [15:0]        ovfl_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, RUN_R, DONE} state_t;
    typedef enum logic {NORMAL = 1'b0, CAPTURE = 1'b1} acache_mode_t;
    typedef enum logic {BPS_16 = 1'b0, BPS_32 = 1'b1} bps_t;

    localparam logic [DEPTH_W:0] FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0] LAST = {1'b0, {DEPTH_W{1'b1}}};

    state_t       state, state_nxt;
    acache_mode_t mode_q;
    bps_t         bps_q;
    logic [31:0]  r_hold;
    logic         xfer;
    logic         arm;
    logic         latch_r;
    logic         last_wr;

    assign pcm_ready = (state != RUN_R);
    assign xfer      = pcm_valid & pcm_ready;
    assign last_wr   = (mode_q == CAPTURE) && (fill_cnt == LAST);
    assign cap_busy  = ((state == RUN) || (state == RUN_R)) && (mode_q == CAPTURE);
    assign cap_done  = (state == DONE);

    assign ram_raddr    = host_rd_addr;
    assign host_rd_data = ram_rdata;

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        latch_r   = 1'b0;
        ram_wr_en = 1'b0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                if (en && ((mode == NORMAL) || cap_start)) begin
                    arm       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Samples offered while en is low are dropped so the exit to IDLE never leaves a half-written pair.
                if (!en) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    ram_wr_en = 1'b1;
                    if (bps_q == BPS_32) begin
                        ram_wdata = pcm_data[63:32];
                        latch_r   = 1'b1;
                        state_nxt = RUN_R;
                    end else begin
                        ram_wdata = {pcm_data[47:32], pcm_data[15:0]};
                        if (last_wr) state_nxt = DONE;
                    end
                end
            end
            RUN_R: begin
                ram_wr_en = 1'b1;
                ram_wdata = r_hold;
                if (!en)          state_nxt = IDLE;
                else if (last_wr) state_nxt = DONE;
                else              state_nxt = RUN;
            end
            DONE: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (cap_start) begin
                    arm       = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= NORMAL;
            bps_q         <= BPS_16;
            ram_waddr     <= '0;
            fill_cnt      <= '0;
            r_hold        <= '0;
            host_rd_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            host_rd_valid <= host_rd_req;
            if (latch_r) r_hold <= pcm_data[31:0];
            if (arm) begin
                mode_q    <= acache_mode_t'(mode);
                bps_q     <= bps_t'(bps);
                ram_waddr <= '0;
                fill_cnt  <= '0;
            end else if (ram_wr_en) begin
                ram_waddr <= ram_waddr + DEPTH_W'(1);
                if (fill_cnt != FULL) fill_cnt <= fill_cnt + (DEPTH_W+1)'(1);
            end
        end
    end

`ifdef SYN_ACACHE_OVFL_CNT_EN
    // Counts samples the source handed over after the capture buffer filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl_cnt <= '0;
        end else if (arm) begin
            ovfl_cnt <= '0;
        end else if ((state == DONE) && xfer && (ovfl_cnt != 16'hFFFF)) begin
            ovfl_cnt <= ovfl_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_syn_acache_ctrl.sv
// Self-checking bench for syn_acache_ctrl (DEPTH_W=3) with a sample-level reference model
// and a behavioural dual-port RAM.
module tb_syn_acache_ctrl;

    localparam int DW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, mode, bps, cap_start, pcm_valid;
    logic [63:0]   pcm_data;
    logic          pcm_ready, ram_wr_en;
    logic [DW-1:0] ram_waddr, ram_raddr, host_rd_addr;
    logic [31:0]   ram_wdata, ram_rdata, host_rd_data;
    logic          host_rd_req, host_rd_valid, cap_busy, cap_done;
    logic [DW:0]   fill_cnt;
`ifdef SYN_ACACHE_OVFL_CNT_EN
    logic [15:0]   ovfl_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [31:0]      mem [DEPTH];
    logic [DW+31:0]   wr_q [$];
    bit               collect = 1'b0;

    always #5 clk = ~clk;

    syn_acache_ctrl #(.DEPTH_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .bps(bps), .cap_start(cap_start),
        .pcm_valid(pcm_valid), .pcm_data(pcm_data), .pcm_ready(pcm_ready),
        .ram_wr_en(ram_wr_en), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
        .cap_busy(cap_busy), .cap_done(cap_done), .fill_cnt(fill_cnt)
`ifdef SYN_ACACHE_OVFL_CNT_EN
        ,
        .ovfl_cnt(ovfl_cnt)
`endif
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
            ram_rdata <= 32'h0;
        end else begin
            if (ram_wr_en) mem[ram_waddr] <= ram_wdata;
            ram_rdata <= mem[ram_raddr];
        end
    end

    always @(negedge clk) begin
        if (collect && ram_wr_en) wr_q.push_back({ram_waddr, ram_wdata});
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; bps = 1'b1; cap_start = 1'b1;
        pcm_valid = 1'b1; pcm_data = {$urandom, $urandom};
        host_rd_req = 1'b0; host_rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (pcm_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", pcm_ready); end
        vectors++; if (ram_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", ram_wr_en); end
        vectors++; if (ram_waddr !== '0) begin errors++; $display("[TB] FAIL reset_waddr: got %0d expected 0", ram_waddr); end
        vectors++; if (fill_cnt !== '0) begin errors++; $display("[TB] FAIL reset_fill: got %0d expected 0", fill_cnt); end
        vectors++; if ({cap_busy, cap_done, host_rd_valid} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {cap_busy, cap_done, host_rd_valid}); end
`ifdef SYN_ACACHE_OVFL_CNT_EN
        vectors++; if (ovfl_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_ovfl: got %0d expected 0", ovfl_cnt); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b0; cap_start = 1'b0; pcm_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Arms the controller, streams random traffic, and compares the RAM write log against the sample model.
    task automatic run_stream(input bit m, input bit b, input int ncyc, input int vpct, input int host_at);
        logic [63:0] acc_q [$];
        logic [31:0] words [$];
        logic [31:0] host_exp;
        bit          prev_stored, exp_ready, exp_hv;
        int          stored, accepted, max_samples, nw, exp_fill;
        stored = 0; accepted = 0; prev_stored = 1'b0; host_exp = '0;
        max_samples = b ? DEPTH / 2 : DEPTH;

        en = 1'b0; pcm_valid = 1'b0; cap_start = 1'b0; host_rd_req = 1'b0;
        @(posedge clk); #1;
        wr_q.delete();
        collect = 1'b1;
        en = 1'b1; mode = m; bps = b; cap_start = m;
        @(posedge clk); #1;
        cap_start = 1'b0;

        for (int c = 0; c < ncyc; c++) begin
            pcm_valid    = ($urandom_range(99) < vpct);
            pcm_data     = {$urandom, $urandom};
            mode         = 1'($urandom);
            bps          = 1'($urandom);
            host_rd_req  = (c == host_at);
            host_rd_addr = (c == host_at) ? DW'(5) : DW'($urandom);
            @(negedge clk);
            exp_ready = !(b && prev_stored);
            vectors++; if (pcm_ready !== exp_ready) begin errors++; $display("[TB] FAIL stream_ready c=%0d: got %b expected %b", c, pcm_ready, exp_ready); end
            exp_hv = (host_at >= 0) && (c == host_at + 1);
            vectors++; if (host_rd_valid !== exp_hv) begin errors++; $display("[TB] FAIL host_valid c=%0d: got %b expected %b", c, host_rd_valid, exp_hv); end
            if (c == host_at) begin
                host_exp = mem[5];
                vectors++; if (ram_raddr !== DW'(5)) begin errors++; $display("[TB] FAIL host_raddr: got %0d expected 5", ram_raddr); end
            end
            if (exp_hv) begin
                vectors++; if (host_rd_data !== host_exp) begin errors++; $display("[TB] FAIL host_data: got %h expected %h", host_rd_data, host_exp); end
            end
            prev_stored = 1'b0;
            if (pcm_valid && exp_ready) begin
                accepted++;
                if (!m || stored < max_samples) begin
                    stored++;
                    prev_stored = 1'b1;
                    acc_q.push_back(pcm_data);
                end
            end
            @(posedge clk); #1;
        end
        pcm_valid = 1'b0; host_rd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        collect = 1'b0;

        foreach (acc_q[i]) begin
            if (b) begin
                words.push_back(acc_q[i][63:32]);
                words.push_back(acc_q[i][31:0]);
            end else begin
                words.push_back({acc_q[i][47:32], acc_q[i][15:0]});
            end
        end
        nw = words.size();
        exp_fill = (nw > DEPTH) ? DEPTH : nw;
        vectors++; if (wr_q.size() != nw) begin errors++; $display("[TB] FAIL write_count: got %0d expected %0d", wr_q.size(), nw); end
        for (int k = 0; k < nw && k < wr_q.size(); k++) begin
            vectors++;
            if (wr_q[k] !== {DW'(k % DEPTH), words[k]}) begin
                errors++; $display("[TB] FAIL write_%0d: got %h expected %h", k, wr_q[k], {DW'(k % DEPTH), words[k]});
            end
        end
        vectors++; if (fill_cnt !== (DW+1)'(exp_fill)) begin errors++; $display("[TB] FAIL fill_cnt: got %0d expected %0d", fill_cnt, exp_fill); end
        vectors++; if (ram_waddr !== DW'(nw % DEPTH)) begin errors++; $display("[TB] FAIL waddr: got %0d expected %0d", ram_waddr, nw % DEPTH); end
        vectors++; if (cap_done !== (m && nw >= DEPTH)) begin errors++; $display("[TB] FAIL cap_done: got %b expected %b", cap_done, (m && nw >= DEPTH)); end
        vectors++; if (cap_busy !== (m && nw < DEPTH)) begin errors++; $display("[TB] FAIL cap_busy: got %b expected %b", cap_busy, (m && nw < DEPTH)); end
`ifdef SYN_ACACHE_OVFL_CNT_EN
        vectors++; if (ovfl_cnt !== 16'(accepted - stored)) begin errors++; $display("[TB] FAIL ovfl_cnt: got %0d expected %0d", ovfl_cnt, accepted - stored); end
`endif
    endtask

    task automatic test_normal_bps16();
        run_stream(1'b0, 1'b0, 10, 100, -1);
    endtask

    task automatic test_capture_bps32();
        run_stream(1'b1, 1'b1, 8, 100, -1);
    endtask

    // Runs straight after a completed capture: extra samples are dropped, then cap_start re-arms.
    task automatic test_rearm();
        logic [63:0] d;
        en = 1'b1; cap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pcm_valid = 1'b1; pcm_data = {$urandom, $urandom};
            @(negedge clk);
            vectors++; if (ram_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL done_no_write %0d: got %b expected 0", i, ram_wr_en); end
            vectors++; if (cap_done !== 1'b1) begin errors++; $display("[TB] FAIL done_flag %0d: got %b expected 1", i, cap_done); end
            @(posedge clk); #1;
        end
        pcm_valid = 1'b0;
`ifdef SYN_ACACHE_OVFL_CNT_EN
        @(negedge clk);
        vectors++; if (ovfl_cnt !== 16'd3) begin errors++; $display("[TB] FAIL ovfl_three: got %0d expected 3", ovfl_cnt); end
        @(posedge clk); #1;
`endif
        mode = 1'b1; bps = 1'b0; cap_start = 1'b1;
        @(posedge clk); #1;
        cap_start = 1'b0; mode = 1'b0; bps = 1'b1;
        d = {$urandom, $urandom};
        pcm_valid = 1'b1; pcm_data = d;
        @(negedge clk);
        vectors++; if (ram_waddr !== '0) begin errors++; $display("[TB] FAIL rearm_waddr: got %0d expected 0", ram_waddr); end
        vectors++; if (fill_cnt !== '0) begin errors++; $display("[TB] FAIL rearm_fill: got %0d expected 0", fill_cnt); end
        vectors++; if ({cap_busy, cap_done} !== 2'b10) begin errors++; $display("[TB] FAIL rearm_flags: got %b expected 10", {cap_busy, cap_done}); end
`ifdef SYN_ACACHE_OVFL_CNT_EN
        vectors++; if (ovfl_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rearm_ovfl: got %0d expected 0", ovfl_cnt); end
`endif
        vectors++; if ({ram_wr_en, ram_wdata} !== {1'b1, d[47:32], d[15:0]}) begin errors++; $display("[TB] FAIL rearm_write: got %b/%h expected 1/%h", ram_wr_en, ram_wdata, {d[47:32], d[15:0]}); end
        @(posedge clk); #1;
        pcm_valid = 1'b0; en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_en_drop_run_r();
        logic [63:0] d;
        en = 1'b0; pcm_valid = 1'b0; cap_start = 1'b0;
        @(posedge clk); #1;
        en = 1'b1; mode = 1'b0; bps = 1'b1;
        @(posedge clk); #1;
        d = {$urandom, $urandom};
        pcm_valid = 1'b1; pcm_data = d;
        @(negedge clk);
        vectors++; if ({ram_wr_en, ram_waddr, ram_wdata} !== {1'b1, DW'(0), d[63:32]}) begin errors++; $display("[TB] FAIL drop_l_write: got %b/%0d/%h expected 1/0/%h", ram_wr_en, ram_waddr, ram_wdata, d[63:32]); end
        @(posedge clk); #1;
        pcm_valid = 1'b0; en = 1'b0; pcm_data = {$urandom, $urandom};
        @(negedge clk);
        vectors++; if ({ram_wr_en, ram_waddr, ram_wdata} !== {1'b1, DW'(1), d[31:0]}) begin errors++; $display("[TB] FAIL drop_r_write: got %b/%0d/%h expected 1/1/%h", ram_wr_en, ram_waddr, ram_wdata, d[31:0]); end
        vectors++; if (pcm_ready !== 1'b0) begin errors++; $display("[TB] FAIL drop_r_ready: got %b expected 0", pcm_ready); end
        @(posedge clk); #1;
        // en back high with CAPTURE and no cap_start: an idle controller must stay idle and ignore the sample.
        en = 1'b1; mode = 1'b1; pcm_valid = 1'b1;
        @(negedge clk);
        vectors++; if ({ram_wr_en, pcm_ready} !== 2'b01) begin errors++; $display("[TB] FAIL drop_idle: got %b expected 01", {ram_wr_en, pcm_ready}); end
        vectors++; if (fill_cnt !== (DW+1)'(2)) begin errors++; $display("[TB] FAIL drop_fill: got %0d expected 2", fill_cnt); end
        @(posedge clk); #1;
        en = 1'b0; pcm_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_run_r();
        wr_q.delete();
        collect = 1'b1;
        en = 1'b1; mode = 1'b1; bps = 1'b1; cap_start = 1'b1;
        @(posedge clk); #1;
        cap_start = 1'b0;
        pcm_valid = 1'b1; pcm_data = {$urandom, $urandom};
        @(posedge clk); #1;
        pcm_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        vectors++; if ({ram_wr_en, pcm_ready} !== 2'b01) begin errors++; $display("[TB] FAIL rstr_wr_ready: got %b expected 01", {ram_wr_en, pcm_ready}); end
        vectors++; if ({ram_waddr, fill_cnt} !== '0) begin errors++; $display("[TB] FAIL rstr_counts: got %0d/%0d expected 0/0", ram_waddr, fill_cnt); end
        vectors++; if ({cap_busy, cap_done, host_rd_valid} !== 3'b000) begin errors++; $display("[TB] FAIL rstr_flags: got %b expected 000", {cap_busy, cap_done, host_rd_valid}); end
        vectors++; if (wr_q.size() != 1) begin errors++; $display("[TB] FAIL rstr_writes: got %0d expected 1", wr_q.size()); end
        collect = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_host_read();
        run_stream(1'b1, 1'b0, 14, 100, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_stream(1'($urandom), 1'($urandom), $urandom_range(20, 45), $urandom_range(30, 95),
                       ($urandom_range(1) == 1) ? $urandom_range(0, 15) : -1);
        end
    endtask

    initial begin
        test_reset();
        test_normal_bps16();
        test_capture_bps32();
        test_rearm();
        test_en_drop_run_r();
        test_reset_run_r();
        test_host_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
